rssi_multi: RTL and testbench



---
 rtl/rssi_pkg.sv | 33 +++
 rtl/rssi_chan.sv | 159 +++++++++++++++
 rtl/rssi_multi.sv | 54 +++++
 tb/tb_rssi_multi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rssi_pkg.sv
// Shared types, default widths and the sample magnitude helper for the rssi_multi
// receive-strength monitor.
package rssi_pkg;

    localparam int DEF_NUM_CH     = 4;
    localparam int DEF_ADC_W      = 12;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_RSSI_SHIFT = 5;
    localparam int DEF_OVER_SHIFT = 10;
    localparam int DEF_DWELL_W    = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        ACTIVE  = 2'd2,
        RELEASE = 2'd3
    } carrier_state_t;

    // One's-complement fold of a width-bit two's-complement sample held in the LSBs;
    // the result keeps width-1 bits, so the most-negative code maps to full scale.
    function automatic logic [31:0] to_abs(input logic [31:0] sample, input int unsigned width);
        logic [31:0] mask;
        logic        sign;
        mask = (32'd1 << (width - 32'd1)) - 32'd1;
        sign = ((sample >> (width - 32'd1)) & 32'd1) != 32'd0;
        if (sign) begin
            return ~sample & mask;
        end else begin
            return sample & mask;
        end
    endfunction

endpackage

// File: rtl/rssi_chan.sv
// One receive channel: leaky magnitude and over-range integrators plus the carrier FSM.
// Optional peak hold is built when RSSI_PEAK_HOLD_EN is defined.
module rssi_chan
    import rssi_pkg::*;
#(
    parameter int ADC_W      = DEF_ADC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int RSSI_SHIFT = DEF_RSSI_SHIFT,
    parameter int OVER_SHIFT = DEF_OVER_SHIFT,
    parameter int DWELL_W    = DEF_DWELL_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [ADC_W-1:0]   adc,
    input  logic [OUT_W-1:0]   on_thresh,
    input  logic [OUT_W-1:0]   off_thresh,
    input  logic [DWELL_W-1:0] dwell,
`ifdef RSSI_PEAK_HOLD_EN
    input  logic               peak_clr,
    output logic [OUT_W-1:0]   peak,
`endif
    output logic [OUT_W-1:0]   rssi,
    output logic [OUT_W-1:0]   over_count,
    output logic               carrier
);

    localparam int RACC_W = OUT_W + RSSI_SHIFT;
    localparam int OACC_W = OUT_W + OVER_SHIFT;

    logic [RACC_W-1:0]  racc_r;
    logic [RACC_W-1:0]  racc_next_s;
    logic [OACC_W-1:0]  oacc_r;
    logic [OACC_W-1:0]  oacc_next_s;
    logic [31:0]        abs_s;
    logic               over_s;
    logic               clear_s;
    logic [OUT_W-1:0]   rssi_cur_s;
    logic [OUT_W-1:0]   rssi_next_s;
    carrier_state_t     state_r;
    carrier_state_t     state_next_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_next_s;
    logic [DWELL_W-1:0] cnt_inc_s;
    logic [DWELL_W-1:0] dwell_last_s;
    logic               carrier_r;
    logic               carrier_next_s;

    assign clear_s     = reset | ~enable;
    assign rssi_cur_s  = racc_r[RACC_W-1 -: OUT_W];
    assign rssi_next_s = racc_next_s[RACC_W-1 -: OUT_W];

    // Integrator updates: each accumulator leaks its own top OUT_W bits every sample.
    always_comb begin
        abs_s       = to_abs({{(32-ADC_W){1'b0}}, adc}, ADC_W);
        over_s      = (adc == {1'b0, {(ADC_W-1){1'b1}}}) || (adc == {1'b1, {(ADC_W-1){1'b0}}});
        racc_next_s = racc_r + RACC_W'(abs_s) - {{RSSI_SHIFT{1'b0}}, rssi_cur_s};
        oacc_next_s = oacc_r
                    + (over_s ? {{OVER_SHIFT{1'b0}}, {OUT_W{1'b1}}} : {OACC_W{1'b0}})
                    - {{OVER_SHIFT{1'b0}}, oacc_r[OACC_W-1 -: OUT_W]};
    end

    // Dwell of 0 behaves as 1; the count is compared with >= so a dwell lowered
    // mid-count still terminates on the next compare.
    always_comb begin
        dwell_last_s = (dwell == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}} : dwell - DWELL_W'(1);
        cnt_inc_s    = (cnt_r == {DWELL_W{1'b1}}) ? cnt_r : cnt_r + DWELL_W'(1);
    end

    // Carrier FSM next state, evaluated on the registered rssi value.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (rssi_cur_s >= on_thresh) begin
                    state_next_s = ATTACK;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else begin
                    state_next_s = IDLE;
                end
            end
            ATTACK: begin
                if (rssi_cur_s < on_thresh) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else if (cnt_r >= dwell_last_s) begin
                    state_next_s = ACTIVE;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else begin
                    cnt_next_s   = cnt_inc_s;
                end
            end
            ACTIVE: begin
                if (rssi_cur_s < off_thresh) begin
                    state_next_s = RELEASE;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            RELEASE: begin
                if (rssi_cur_s >= off_thresh) begin
                    state_next_s = ACTIVE;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else if (cnt_r >= dwell_last_s) begin
                    state_next_s = IDLE;
                    cnt_next_s   = {DWELL_W{1'b0}};
                end else begin
                    cnt_next_s   = cnt_inc_s;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = {DWELL_W{1'b0}};
            end
        endcase
        carrier_next_s = (state_next_s == ACTIVE) || (state_next_s == RELEASE);
    end

    // Channel state registers; reset or a low enable abandons everything.
    always_ff @(posedge clock) begin
        if (clear_s) begin
            racc_r    <= {RACC_W{1'b0}};
            oacc_r    <= {OACC_W{1'b0}};
            state_r   <= IDLE;
            cnt_r     <= {DWELL_W{1'b0}};
            carrier_r <= 1'b0;
        end else begin
            racc_r    <= racc_next_s;
            oacc_r    <= oacc_next_s;
            state_r   <= state_next_s;
            cnt_r     <= cnt_next_s;
            carrier_r <= carrier_next_s;
        end
    end

`ifdef RSSI_PEAK_HOLD_EN
    logic [OUT_W-1:0] peak_r;

    // Peak tracks the rssi value appearing this cycle; a clear reloads from it.
    always_ff @(posedge clock) begin
        if (clear_s) begin
            peak_r <= {OUT_W{1'b0}};
        end else if (peak_clr || (rssi_next_s > peak_r)) begin
            peak_r <= rssi_next_s;
        end else begin
            peak_r <= peak_r;
        end
    end

    assign peak = peak_r;
`endif

    assign rssi       = rssi_cur_s;
    assign over_count = oacc_r[OACC_W-1 -: OUT_W];
    assign carrier    = carrier_r;

endmodule

// File: rtl/rssi_multi.sv
// Multi-channel RSSI / ADC over-range monitor: replicates rssi_chan and packs ports.
// Define RSSI_PEAK_HOLD_EN to add per-channel peak hold (peak_clr / peak ports).
module rssi_multi
    import rssi_pkg::*;
#(
    parameter int NUM_CH     = DEF_NUM_CH,
    parameter int ADC_W      = DEF_ADC_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int RSSI_SHIFT = DEF_RSSI_SHIFT,
    parameter int OVER_SHIFT = DEF_OVER_SHIFT,
    parameter int DWELL_W    = DEF_DWELL_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*ADC_W-1:0] adc,
    input  logic [OUT_W-1:0]        on_thresh,
    input  logic [OUT_W-1:0]        off_thresh,
    input  logic [DWELL_W-1:0]      dwell,
`ifdef RSSI_PEAK_HOLD_EN
    input  logic [NUM_CH-1:0]       peak_clr,
    output logic [NUM_CH*OUT_W-1:0] peak,
`endif
    output logic [NUM_CH*OUT_W-1:0] rssi,
    output logic [NUM_CH*OUT_W-1:0] over_count,
    output logic [NUM_CH-1:0]       carrier
);

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_chan
        rssi_chan #(
            .ADC_W      (ADC_W),
            .OUT_W      (OUT_W),
            .RSSI_SHIFT (RSSI_SHIFT),
            .OVER_SHIFT (OVER_SHIFT),
            .DWELL_W    (DWELL_W)
        ) u_chan (
            .clock      (clock),
            .reset      (reset),
            .enable     (enable[ch]),
            .adc        (adc[ch*ADC_W +: ADC_W]),
            .on_thresh  (on_thresh),
            .off_thresh (off_thresh),
            .dwell      (dwell),
`ifdef RSSI_PEAK_HOLD_EN
            .peak_clr   (peak_clr[ch]),
            .peak       (peak[ch*OUT_W +: OUT_W]),
`endif
            .rssi       (rssi[ch*OUT_W +: OUT_W]),
            .over_count (over_count[ch*OUT_W +: OUT_W]),
            .carrier    (carrier[ch])
        );
    end

endmodule

// File: tb/tb_rssi_multi.sv
// Scoreboard bench for rssi_multi: an arithmetic reference model pushes expected
// outputs per cycle, a monitor pops and compares after each clock edge.
module tb_rssi_multi;

    localparam int NCH = 4;
    localparam int AW  = 12;
    localparam int OW  = 16;

    logic              clock = 1'b0;
    logic              reset;
    logic [NCH-1:0]    enable;
    logic [NCH*AW-1:0] adc;
    logic [OW-1:0]     on_thresh;
    logic [OW-1:0]     off_thresh;
    logic [7:0]        dwell;
    logic [NCH*OW-1:0] rssi;
    logic [NCH*OW-1:0] over_count;
    logic [NCH-1:0]    carrier;
`ifdef RSSI_PEAK_HOLD_EN
    logic [NCH-1:0]    peak_clr;
    logic [NCH*OW-1:0] peak;
`endif

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [NCH*OW-1:0] rssi;
        logic [NCH*OW-1:0] over;
        logic [NCH-1:0]    car;
        logic [NCH*OW-1:0] peak;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state, in plain integers
    int m_racc[NCH];
    int m_oacc[NCH];
    int m_run[NCH];
    int m_peak[NCH];
    bit m_car[NCH];

    always #5 clock = ~clock;

    rssi_multi dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .adc        (adc),
        .on_thresh  (on_thresh),
        .off_thresh (off_thresh),
        .dwell      (dwell),
`ifdef RSSI_PEAK_HOLD_EN
        .peak_clr   (peak_clr),
        .peak       (peak),
`endif
        .rssi       (rssi),
        .over_count (over_count),
        .carrier    (carrier)
    );

    task automatic model_step();
        exp_t e;
        for (int ch = 0; ch < NCH; ch++) begin
            int  s, mag, r_old, r_new, dw;
            bit  side, ov, clr;
            logic [AW-1:0] smp;
            clr = 1'b0;
`ifdef RSSI_PEAK_HOLD_EN
            clr = peak_clr[ch];
`endif
            if (reset || !enable[ch]) begin
                m_racc[ch] = 0; m_oacc[ch] = 0; m_run[ch] = 0; m_peak[ch] = 0; m_car[ch] = 1'b0;
            end else begin
                smp   = adc[ch*AW +: AW];
                s     = int'($signed(smp));
                mag   = (s < 0) ? (-s - 1) : s;
                r_old = m_racc[ch] / 32;
                dw    = (dwell == 8'd0) ? 1 : int'(dwell);
                // carrier flips once the far side of its threshold has been seen on more than dwell compares in a row
                side  = m_car[ch] ? (r_old < int'(off_thresh)) : (r_old >= int'(on_thresh));
                if (side) begin
                    m_run[ch]++;
                    if (m_run[ch] > dw) begin
                        m_car[ch] = !m_car[ch];
                        m_run[ch] = 0;
                    end
                end else begin
                    m_run[ch] = 0;
                end
                m_racc[ch] = m_racc[ch] + mag - r_old;
                ov         = (s == 2047) || (s == -2048);
                m_oacc[ch] = m_oacc[ch] + (ov ? 65535 : 0) - m_oacc[ch] / 1024;
                r_new      = m_racc[ch] / 32;
                if (clr || r_new > m_peak[ch]) m_peak[ch] = r_new;
            end
            e.rssi[ch*OW +: OW] = OW'(m_racc[ch] / 32);
            e.over[ch*OW +: OW] = OW'(m_oacc[ch] / 1024);
            e.car[ch]           = m_car[ch];
            e.peak[ch*OW +: OW] = OW'(m_peak[ch]);
        end
        exp_q.push_back(e);
    endtask

    // One clock: model the inputs now applied, then let the DUT take the edge.
    task automatic cycle();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_adc(input int ch, input int v);
        logic [31:0] t;
        t = v;
        adc[ch*AW +: AW] = t[AW-1:0];
    endtask

    task automatic check(input string name, input int got, input int expv);
        compared++;
        if (got != expv) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, expv);
        end
    endtask

    // Monitor: every edge presents a fresh output set, so pop one entry per edge.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int ch = 0; ch < NCH; ch++) begin
                bit bad;
                bad = (rssi[ch*OW +: OW] !== e.rssi[ch*OW +: OW]) ||
                      (over_count[ch*OW +: OW] !== e.over[ch*OW +: OW]) ||
                      (carrier[ch] !== e.car[ch]);
`ifdef RSSI_PEAK_HOLD_EN
                bad = bad || (peak[ch*OW +: OW] !== e.peak[ch*OW +: OW]);
`endif
                compared++;
                if (bad) begin
                    mismatched++;
                    $display("FAIL scoreboard ch%0d t=%0t: got rssi=%0d over=%0d car=%0b, expected rssi=%0d over=%0d car=%0b",
                             ch, $time, rssi[ch*OW +: OW], over_count[ch*OW +: OW], carrier[ch],
                             e.rssi[ch*OW +: OW], e.over[ch*OW +: OW], e.car[ch]);
                end
            end
        end
    end

    initial begin
        int mode[NCH];
        int lvl[NCH];
        reset = 1'b1; enable = '0; adc = '0;
        on_thresh = 16'd500; off_thresh = 16'd300; dwell = 8'd4;
`ifdef RSSI_PEAK_HOLD_EN
        peak_clr = '0;
`endif
        @(negedge clock);
        repeat (2) cycle();

        // Constant magnitude on channel 0, others idle at zero
        reset = 1'b0; enable = 4'b1111;
        set_adc(0, 100);
        cycle();
        check("rssi_first_sample", int'(rssi[15:0]), 3);
        repeat (400) cycle();
        check("rssi_steady_100", int'(rssi[15:0]), 100);
        check("idle_ch1_rssi", int'(rssi[31:16]), 0);
        check("idle_ch3_rssi", int'(rssi[63:48]), 0);

        // Over-range at both full-scale codes
        set_adc(1, 2047); set_adc(2, -2048);
        cycle();
        check("over_first_pos", int'(over_count[31:16]), 63);
        check("over_first_neg", int'(over_count[47:32]), 63);
        repeat (16000) cycle();
        check("over_conv_pos", int'(over_count[31:16]), 65535);
        check("over_conv_neg", int'(over_count[47:32]), 65535);
        check("rssi_conv_pos", int'(rssi[31:16]), 2047);
        check("rssi_conv_neg", int'(rssi[47:32]), 2047);

        // Carrier timing on channel 3, steered by thresholds around a steady rssi of 600
        set_adc(3, 600); on_thresh = 16'd700;
        repeat (400) cycle();
        check("rssi_steady_600", int'(rssi[63:48]), 600);
        on_thresh = 16'd500;
        repeat (2) cycle();
        on_thresh = 16'd700;
        repeat (6) cycle();
        check("blip_no_carrier", int'(carrier[3]), 0);
        on_thresh = 16'd500;
        repeat (4) cycle();
        check("rise_before_dwell", int'(carrier[3]), 0);
        cycle();
        check("rise_after_dwell", int'(carrier[3]), 1);
        on_thresh = 16'd650; off_thresh = 16'd550;
        repeat (10) cycle();
        check("hysteresis_hold", int'(carrier[3]), 1);
        off_thresh = 16'd700;
        repeat (2) cycle();
        off_thresh = 16'd300;
        repeat (6) cycle();
        check("dip_keeps_carrier", int'(carrier[3]), 1);
        off_thresh = 16'd700;
        repeat (4) cycle();
        check("fall_before_dwell", int'(carrier[3]), 1);
        cycle();
        check("fall_after_dwell", int'(carrier[3]), 0);
        on_thresh = 16'd500; off_thresh = 16'd300;

        // Enable drop on channel 1 while active, then while ramping
        repeat (10) cycle();
        enable = 4'b1101;
        cycle();
        check("en_off_rssi", int'(rssi[31:16]), 0);
        check("en_off_over", int'(over_count[31:16]), 0);
        check("en_off_carrier", int'(carrier[1]), 0);
        enable = 4'b1111;
        repeat (12) cycle();
        enable = 4'b1101;
        cycle();
        check("en_off_ramp_rssi", int'(rssi[31:16]), 0);
        enable = 4'b1111;
        repeat (5) cycle();

        // Synchronous reset pulse clears every channel
        reset = 1'b1;
        cycle();
        check("srst_rssi", int'(rssi != '0), 0);
        check("srst_over", int'(over_count != '0), 0);
        check("srst_carrier", int'(carrier), 0);
        reset = 1'b0;

`ifdef RSSI_PEAK_HOLD_EN
        set_adc(0, 900);
        repeat (400) cycle();
        set_adc(0, 0);
        repeat (50) cycle();
        check("peak_hold_900", int'(peak[15:0]), 900);
        set_adc(0, 450);
        repeat (400) cycle();
        peak_clr = 4'b0001;
        cycle();
        peak_clr = '0;
        check("peak_clr_450", int'(peak[15:0]), 450);
`endif

        // Randomised traffic: levels, noise, over-range, threshold/dwell/enable/reset churn
        for (int ch = 0; ch < NCH; ch++) begin
            mode[ch] = 0; lvl[ch] = int'($urandom_range(0, 2047));
        end
        for (int n = 0; n < 4000; n++) begin
            for (int ch = 0; ch < NCH; ch++) begin
                int v;
                if ($urandom_range(0, 199) == 0) begin
                    mode[ch] = int'($urandom_range(0, 2));
                    lvl[ch]  = int'($urandom_range(0, 2047));
                end
                case (mode[ch])
                    0: begin
                        v = lvl[ch] + int'($urandom_range(0, 40)) - 20;
                        if ($urandom_range(0, 1) == 1) v = -v;
                        if (v > 2047) v = 2047;
                        if (v < -2048) v = -2048;
                    end
                    1: v = int'($urandom_range(0, 4095)) - 2048;
                    default: v = ($urandom_range(0, 1) == 1) ? 2047 : -2048;
                endcase
                set_adc(ch, v);
            end
            enable = 4'b1111;
            for (int ch = 0; ch < NCH; ch++)
                if ($urandom_range(0, 299) == 0) enable[ch] = 1'b0;
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 99) == 0) on_thresh = 16'($urandom_range(0, 2047));
            if ($urandom_range(0, 99) == 0) off_thresh = 16'($urandom_range(0, 2047));
            if ($urandom_range(0, 99) == 0) dwell = 8'($urandom_range(0, 7));
`ifdef RSSI_PEAK_HOLD_EN
            for (int ch = 0; ch < NCH; ch++)
                peak_clr[ch] = ($urandom_range(0, 39) == 0);
`endif
            cycle();
        end
        reset = 1'b0;

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clock);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
